// File: rtl/led_pwm_driver_pkg.sv
// rtl/led_pwm_driver_pkg.sv - shared constants for the LED PWM driver
// Contents: write-select codes for the three duty registers and the blink control register.
package led_pwm_driver_pkg;

  localparam logic [1:0] SEL_R     = 2'd0;
  localparam logic [1:0] SEL_G     = 2'd1;
  localparam logic [1:0] SEL_B     = 2'd2;
  localparam logic [1:0] SEL_BLINK = 2'd3;

  localparam int NUM_CH = 3;

endpackage

// File: rtl/led_pwm_driver_if.sv
// rtl/led_pwm_driver_if.sv - CPU write port of the LED PWM driver
// Signals: wr_en (one-clk strobe), wr_sel (register select), wr_data (duty or blink control).
// Modports: master drives the write strobe, slave (the driver) receives it.
interface led_pwm_driver_if #(
  parameter int PWM_BITS = 8
) ();

  logic                wr_en;
  logic [1:0]          wr_sel;
  logic [PWM_BITS-1:0] wr_data;

  modport master (output wr_en, output wr_sel, output wr_data);
  modport slave  (input  wr_en, input  wr_sel, input  wr_data);

endinterface

// File: rtl/led_pwm_tick.sv
// rtl/led_pwm_tick.sv - prescaler producing one PWM step tick every PRESCALE+1 clocks
// Ports: clk, rst (async active-high) in; tick_o out, high on the last clock of each prescale interval.
module led_pwm_tick #(
  parameter int PRESCALE = 47
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  // A zero prescale still needs a one-bit counter; it simply never leaves 0.
  localparam int W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE);

  logic [W-1:0] presc_q, presc_d;

  always_comb begin
    tick_o  = (presc_q == LAST);
    presc_d = tick_o ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - three-channel LED PWM driver with period-aligned duty reload and blink gating
// Ports: clk, rst (async active-high) in; wr_if (slave write port) in;
//        period_end out (1-clk pulse when active settings reload); led_r/led_g/led_b out (PWM pins).
module led_pwm_driver
  import led_pwm_driver_pkg::*;
#(
  parameter int PRESCALE   = 47,
  parameter int PWM_BITS   = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  led_pwm_driver_if.slave         wr_if,
  output logic                    period_end,
  output logic                    led_r,
  output logic                    led_g,
  output logic                    led_b
);

  localparam int HB = PWM_BITS - 1;

  logic tick;
  logic wrap;
  logic blink_on;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  // Pending registers take CPU writes; active registers drive the outputs
  // and are only refreshed on a period wrap so a period is never cut short.
  logic [NUM_CH-1:0][PWM_BITS-1:0] pend_duty_q, pend_duty_d;
  logic [NUM_CH-1:0][PWM_BITS-1:0] act_duty_q, act_duty_d;
  logic                            pend_blink_en_q, pend_blink_en_d;
  logic                            act_blink_en_q, act_blink_en_d;
  logic [HB-1:0]                   pend_half_q, pend_half_d;
  logic [HB-1:0]                   act_half_q, act_half_d;

  logic [HB-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [NUM_CH-1:0]   led_q, led_d;
  logic                period_end_q, period_end_d;

  led_pwm_tick #(.PRESCALE(PRESCALE)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  assign wrap     = tick && (pwm_cnt_q == '1);
  assign blink_on = act_blink_en_q && (act_half_q != '0);

  always_comb begin
    pwm_cnt_d       = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;

    pend_duty_d     = pend_duty_q;
    pend_blink_en_d = pend_blink_en_q;
    pend_half_d     = pend_half_q;
    if (wr_if.wr_en) begin
      case (wr_if.wr_sel)
        SEL_R:     pend_duty_d[0] = wr_if.wr_data;
        SEL_G:     pend_duty_d[1] = wr_if.wr_data;
        SEL_B:     pend_duty_d[2] = wr_if.wr_data;
        SEL_BLINK: begin
          pend_blink_en_d = wr_if.wr_data[0];
          pend_half_d     = wr_if.wr_data[PWM_BITS-1:1];
        end
      endcase
    end

    // Loading from the next-state pending values lets a write landing on the
    // wrap edge go straight into the new period.
    act_duty_d     = act_duty_q;
    act_blink_en_d = act_blink_en_q;
    act_half_d     = act_half_q;
    if (wrap) begin
      act_duty_d     = pend_duty_d;
      act_blink_en_d = pend_blink_en_d;
      act_half_d     = pend_half_d;
    end

    // Blink counts completed periods under the settings of the period just ending;
    // the >= compare recovers cleanly when half-period shrinks below the count.
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!blink_on) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (wrap) begin
      if (blink_cnt_q >= act_half_q - 1'b1) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Gating also checks blink_on so a stale phase from a just-disabled blink never blanks a clock.
    led_d[0] = (pwm_cnt_q < act_duty_q[0]) && !(blink_phase_q && blink_on);
    led_d[1] = (pwm_cnt_q < act_duty_q[1]) && !(blink_phase_q && blink_on);
    led_d[2] = (pwm_cnt_q < act_duty_q[2]) && !(blink_phase_q && blink_on);

    period_end_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q       <= '0;
      pend_duty_q     <= '0;
      act_duty_q      <= '0;
      pend_blink_en_q <= 1'b0;
      act_blink_en_q  <= 1'b0;
      pend_half_q     <= '0;
      act_half_q      <= '0;
      blink_cnt_q     <= '0;
      blink_phase_q   <= 1'b0;
      led_q           <= '0;
      period_end_q    <= 1'b0;
    end else begin
      pwm_cnt_q       <= pwm_cnt_d;
      pend_duty_q     <= pend_duty_d;
      act_duty_q      <= act_duty_d;
      pend_blink_en_q <= pend_blink_en_d;
      act_blink_en_q  <= act_blink_en_d;
      pend_half_q     <= pend_half_d;
      act_half_q      <= act_half_d;
      blink_cnt_q     <= blink_cnt_d;
      blink_phase_q   <= blink_phase_d;
      led_q           <= led_d;
      period_end_q    <= period_end_d;
    end
  end

  // Polarity is applied last so the reset value also reads as "off" on the pin.
  assign led_r      = led_q[0] ^ ACTIVE_LOW;
  assign led_g      = led_q[1] ^ ACTIVE_LOW;
  assign led_b      = led_q[2] ^ ACTIVE_LOW;
  assign period_end = period_end_q;

endmodule
